// File: rtl/bench_axi_sequencer.sv
// AXI4-Lite master that runs back-to-back router benchmark iterations:
// write CONTROL.start, poll STATUS until done, read TCOND0..3, then accumulate sums and winner histograms.
module bench_axi_sequencer #(
  parameter int RUNS     = 16,
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT  = 65535
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] run_count,
  output logic [47:0] sum0,
  output logic [47:0] sum1,
  output logic [47:0] sum2,
  output logic [47:0] sum3,
  output logic [15:0] win_cnt0,
  output logic [15:0] win_cnt1,
  output logic [15:0] win_cnt2,
  output logic [15:0] win_cnt3,
  output logic [5:0]  m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [5:0]  m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE, WR_START, WAIT_B, GAP, RD_STAT, RD_T, ACCUM, FIN
  } state_t;

  state_t      state_r, state_nx_s;
  logic        awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
  logic [5:0]  araddr_r;
  logic        busy_r, done_r, error_r;
  logic [15:0] run_count_r, poll_cnt_r, gap_cnt_r;
  logic [1:0]  winner_r, t_idx_r;
  logic [31:0] t_r   [4];
  logic [47:0] sum_r [4];
  logic [15:0] win_r [4];

  logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, wr_done_s;

  assign aw_hs_s   = awvalid_r & m_axi_awready;
  assign w_hs_s    = wvalid_r & m_axi_wready;
  assign b_hs_s    = bready_r & m_axi_bvalid;
  assign ar_hs_s   = arvalid_r & m_axi_arready;
  assign r_hs_s    = rready_r & m_axi_rvalid;
  // Address and data phases may complete in either order or together.
  assign wr_done_s = (~awvalid_r | m_axi_awready) & (~wvalid_r | m_axi_wready);

  // State register.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:     if (start) state_nx_s = WR_START; else state_nx_s = IDLE;
      WR_START: if (wr_done_s) state_nx_s = WAIT_B; else state_nx_s = WR_START;
      WAIT_B: begin
        if (b_hs_s) state_nx_s = (m_axi_bresp != 2'b00) ? FIN : GAP;
        else        state_nx_s = WAIT_B;
      end
      GAP: begin
        if (gap_cnt_r == 16'(POLL_GAP - 1)) state_nx_s = RD_STAT;
        else                                state_nx_s = GAP;
      end
      RD_STAT: begin
        if (!r_hs_s)                           state_nx_s = RD_STAT;
        else if (m_axi_rresp != 2'b00)         state_nx_s = FIN;
        else if (m_axi_rdata[1])               state_nx_s = RD_T;
        else if (poll_cnt_r == 16'(TIMEOUT - 1)) state_nx_s = FIN;
        else                                   state_nx_s = GAP;
      end
      RD_T: begin
        if (!r_hs_s)                   state_nx_s = RD_T;
        else if (m_axi_rresp != 2'b00) state_nx_s = FIN;
        else if (t_idx_r == 2'd3)      state_nx_s = ACCUM;
        else                           state_nx_s = RD_T;
      end
      ACCUM: begin
        if (run_count_r + 16'd1 == 16'(RUNS)) state_nx_s = FIN;
        else                                  state_nx_s = WR_START;
      end
      FIN:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Channel handshakes, counters and accumulators.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      araddr_r    <= 6'h00;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      run_count_r <= 16'd0;
      poll_cnt_r  <= 16'd0;
      gap_cnt_r   <= 16'd0;
      winner_r    <= 2'd0;
      t_idx_r     <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        t_r[i]   <= 32'd0;
        sum_r[i] <= 48'd0;
        win_r[i] <= 16'd0;
      end
    end else begin
      done_r <= 1'b0;
      if (aw_hs_s) awvalid_r <= 1'b0;
      if (w_hs_s)  wvalid_r  <= 1'b0;
      if (b_hs_s)  bready_r  <= 1'b0;
      if (ar_hs_s) begin
        arvalid_r <= 1'b0;
        rready_r  <= 1'b1;
      end
      if (r_hs_s)  rready_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            busy_r      <= 1'b1;
            error_r     <= 1'b0;
            run_count_r <= 16'd0;
            awvalid_r   <= 1'b1;
            wvalid_r    <= 1'b1;
            for (int i = 0; i < 4; i++) begin
              sum_r[i] <= 48'd0;
              win_r[i] <= 16'd0;
            end
          end
        end
        WR_START: if (wr_done_s) bready_r <= 1'b1;
        WAIT_B: begin
          if (b_hs_s) begin
            gap_cnt_r  <= 16'd0;
            poll_cnt_r <= 16'd0;
            if (m_axi_bresp != 2'b00) error_r <= 1'b1;
          end
        end
        GAP: begin
          gap_cnt_r <= gap_cnt_r + 16'd1;
          if (state_nx_s == RD_STAT) begin
            arvalid_r <= 1'b1;
            araddr_r  <= 6'h04;
          end
        end
        RD_STAT: begin
          if (r_hs_s) begin
            if (m_axi_rresp != 2'b00) begin
              error_r <= 1'b1;
            end else if (m_axi_rdata[1]) begin
              winner_r  <= m_axi_rdata[3:2];
              t_idx_r   <= 2'd0;
              arvalid_r <= 1'b1;
              araddr_r  <= 6'h08;
            end else begin
              poll_cnt_r <= poll_cnt_r + 16'd1;
              gap_cnt_r  <= 16'd0;
              if (poll_cnt_r == 16'(TIMEOUT - 1)) error_r <= 1'b1;
            end
          end
        end
        RD_T: begin
          if (r_hs_s) begin
            if (m_axi_rresp != 2'b00) begin
              error_r <= 1'b1;
            end else begin
              t_r[t_idx_r] <= m_axi_rdata;
              if (t_idx_r != 2'd3) begin
                t_idx_r   <= t_idx_r + 2'd1;
                arvalid_r <= 1'b1;
                araddr_r  <= araddr_r + 6'h04;
              end
            end
          end
        end
        ACCUM: begin
          for (int i = 0; i < 4; i++) sum_r[i] <= sum_r[i] + {16'd0, t_r[i]};
          win_r[winner_r] <= win_r[winner_r] + 16'd1;
          run_count_r     <= run_count_r + 16'd1;
          if (state_nx_s == WR_START) begin
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
          end
        end
        FIN: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
  assign run_count     = run_count_r;
  assign sum0          = sum_r[0];
  assign sum1          = sum_r[1];
  assign sum2          = sum_r[2];
  assign sum3          = sum_r[3];
  assign win_cnt0      = win_r[0];
  assign win_cnt1      = win_r[1];
  assign win_cnt2      = win_r[2];
  assign win_cnt3      = win_r[3];
  assign m_axi_awaddr  = 6'h00;
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_wdata   = 32'h0000_0001;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_r;
  assign m_axi_bready  = bready_r;
  assign m_axi_araddr  = araddr_r;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_rready  = rready_r;

endmodule

// File: tb/tb_bench_axi_sequencer.sv
// Directed bench: a behavioural AXI4-Lite router slave with tunable latencies, stuck-done and
// error injection, driven through nominal, timeout, SLVERR, skewed-write and reset-abort scenarios.
module tb_bench_axi_sequencer;

  logic        clk, aresetn, start;
  logic        busy, done, error;
  logic [15:0] run_count, win_cnt0, win_cnt1, win_cnt2, win_cnt3;
  logic [47:0] sum0, sum1, sum2, sum3;
  logic [5:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int total = 0;
  int bad   = 0;

  // Slave knobs, written only by the stimulus block.
  int         aw_delay = 1;
  int         w_delay  = 1;
  logic       never_done = 1'b0;
  int         err_run  = 0;
  int         err_idx  = 0;
  logic [1:0] winner   = 2'd2;

  // Slave state and monitors.
  int   aw_wait, w_wait, polls, runs, status_reads, aw_hs_n, w_hs_n, overlap_n, bad_wr_n;
  logic got_aw, got_w, rd_pend, wr_pend, saw_split;
  logic [1:0] ar_idx;
  assign ar_idx = araddr[3:2] - 2'd2;

  bench_axi_sequencer #(.RUNS(4), .POLL_GAP(4), .TIMEOUT(100)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn), .start(start),
    .busy(busy), .done(done), .error(error), .run_count(run_count),
    .sum0(sum0), .sum1(sum1), .sum2(sum2), .sum3(sum3),
    .win_cnt0(win_cnt0), .win_cnt1(win_cnt1), .win_cnt2(win_cnt2), .win_cnt3(win_cnt3),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural router slave plus protocol monitors.
  always @(posedge clk) begin
    if (!aresetn) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; arready <= 1'b0; rvalid <= 1'b0;
      bresp <= 2'b00; rresp <= 2'b00; rdata <= 32'd0;
      aw_wait <= 0; w_wait <= 0; polls <= 0; runs <= 0; status_reads <= 0;
      aw_hs_n <= 0; w_hs_n <= 0; overlap_n <= 0; bad_wr_n <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; rd_pend <= 1'b0; wr_pend <= 1'b0; saw_split <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        awready <= 1'b0; aw_wait <= 0; got_aw <= 1'b1; wr_pend <= 1'b1;
        aw_hs_n <= aw_hs_n + 1;
        if (awaddr != 6'h00) bad_wr_n <= bad_wr_n + 1;
      end else if (awvalid) begin
        aw_wait <= aw_wait + 1;
        if (aw_wait + 1 >= aw_delay) awready <= 1'b1;
      end
      if (wvalid && wready) begin
        wready <= 1'b0; w_wait <= 0; got_w <= 1'b1;
        w_hs_n <= w_hs_n + 1;
        if (wdata != 32'd1 || wstrb != 4'hF) bad_wr_n <= bad_wr_n + 1;
      end else if (wvalid) begin
        w_wait <= w_wait + 1;
        if (w_wait + 1 >= w_delay) wready <= 1'b1;
      end
      if (got_aw && got_w && !bvalid) begin
        bvalid <= 1'b1; bresp <= 2'b00; got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; wr_pend <= 1'b0; runs <= runs + 1; polls <= 0;
      end
      if (arvalid && arready) begin
        arready <= 1'b0; rd_pend <= 1'b1; rvalid <= 1'b1;
        if (araddr == 6'h04) begin
          status_reads <= status_reads + 1;
          polls <= polls + 1;
          rdata <= {28'd0, winner, (!never_done && polls >= 2), 1'b0};
          rresp <= 2'b00;
        end else if (araddr >= 6'h08 && araddr <= 6'h14 && araddr[1:0] == 2'b00) begin
          rdata <= {30'd0, ar_idx} * 32'd10 + 32'd10;
          rresp <= (runs == err_run && int'(ar_idx) == err_idx) ? 2'b10 : 2'b00;
        end else begin
          rdata <= 32'd0;
          rresp <= 2'b11;
        end
      end else if (arvalid && !rd_pend && !rvalid && !arready) begin
        arready <= 1'b1;
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0; rd_pend <= 1'b0;
      end
      if ((awvalid || wvalid) && (arvalid || rd_pend)) overlap_n <= overlap_n + 1;
      if (arvalid && wr_pend) overlap_n <= overlap_n + 1;
      if (awvalid && !wvalid) saw_split <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) aresetn = 1'b0;
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {63'd0, done}, 64'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    aresetn = 1'b0;
    start   = 1'b0;
    do_reset();

    // Reset state
    chk("rst_flags", {56'd0, awvalid, wvalid, arvalid, bready, rready, busy, done, error}, 64'd0);
    chk("rst_run_count", {48'd0, run_count}, 64'd0);
    chk("rst_sum0", {16'd0, sum0}, 64'd0);

    // Nominal: 4 runs, winner 2, with a stray start mid-sequence
    pulse_start();
    chk("t1_busy", {63'd0, busy}, 64'd1);
    repeat (30) @(negedge clk);
    pulse_start();
    wait_done("t1_done");
    chk("t1_sum0", {16'd0, sum0}, 64'd40);
    chk("t1_sum1", {16'd0, sum1}, 64'd80);
    chk("t1_sum2", {16'd0, sum2}, 64'd120);
    chk("t1_sum3", {16'd0, sum3}, 64'd160);
    chk("t1_win", {win_cnt3, win_cnt2, win_cnt1, win_cnt0}, {16'd0, 16'd4, 16'd0, 16'd0});
    chk("t1_run_count", {48'd0, run_count}, 64'd4);
    chk("t1_error", {63'd0, error}, 64'd0);
    chk("t1_busy_low", {63'd0, busy}, 64'd0);
    chk("t1_start_writes", 64'(aw_hs_n), 64'd4);
    chk("t1_status_reads", 64'(status_reads), 64'd12);
    chk("t1_overlap", 64'(overlap_n), 64'd0);
    chk("t1_bad_write", 64'(bad_wr_n), 64'd0);
    repeat (5) @(negedge clk);
    chk("t1_hold_sum3", {16'd0, sum3}, 64'd160);

    // Slave never reports done: exactly TIMEOUT polls then abort
    do_reset();
    never_done = 1'b1;
    pulse_start();
    wait_done("t2_done");
    chk("t2_status_reads", 64'(status_reads), 64'd100);
    chk("t2_error", {63'd0, error}, 64'd1);
    chk("t2_run_count", {48'd0, run_count}, 64'd0);
    chk("t2_busy", {63'd0, busy}, 64'd0);
    repeat (5) @(negedge clk);
    chk("t2_error_sticky", {63'd0, error}, 64'd1);
    never_done = 1'b0;

    // SLVERR on TCOND2 of run 2
    do_reset();
    err_run = 2;
    err_idx = 2;
    pulse_start();
    wait_done("t3_done");
    chk("t3_error", {63'd0, error}, 64'd1);
    chk("t3_run_count", {48'd0, run_count}, 64'd1);
    chk("t3_sums", {sum3[15:0], sum2[15:0], sum1[15:0], sum0[15:0]}, {16'd40, 16'd30, 16'd20, 16'd10});
    chk("t3_win2", {48'd0, win_cnt2}, 64'd1);
    chk("t3_busy", {63'd0, busy}, 64'd0);
    err_run = 0;

    // wready leads awready by 3 cycles; winner 1
    do_reset();
    aw_delay = 4;
    w_delay  = 1;
    winner   = 2'd1;
    pulse_start();
    chk("t4_error_cleared", {63'd0, error}, 64'd0);
    wait_done("t4_done");
    chk("t4_split_seen", {63'd0, saw_split}, 64'd1);
    chk("t4_aw_count", 64'(aw_hs_n), 64'd4);
    chk("t4_w_count", 64'(w_hs_n), 64'd4);
    chk("t4_win", {win_cnt3, win_cnt2, win_cnt1, win_cnt0}, {16'd0, 16'd0, 16'd4, 16'd0});
    chk("t4_sum2", {16'd0, sum2}, 64'd120);
    chk("t4_overlap", 64'(overlap_n), 64'd0);
    aw_delay = 1;
    winner   = 2'd2;

    // Reset while a STATUS read is in flight
    do_reset();
    pulse_start();
    begin
      int n;
      n = 0;
      while (!(arvalid === 1'b1 && araddr === 6'h04) && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("t5_reached_rd_stat", {63'd0, arvalid}, 64'd1);
    end
    aresetn = 1'b0;
    @(negedge clk);
    chk("t5_rst_flags", {56'd0, awvalid, wvalid, arvalid, bready, rready, busy, done, error}, 64'd0);
    chk("t5_rst_run_count", {48'd0, run_count}, 64'd0);
    aresetn = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_idle_after", {61'd0, busy, arvalid, awvalid}, 64'd0);
    pulse_start();
    wait_done("t5_recover_done");
    chk("t5_recover_run_count", {48'd0, run_count}, 64'd4);
    chk("t5_recover_sum1", {16'd0, sum1}, 64'd80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
